// File: rtl/zuma_lutram_bank.sv
// ---------------------------------------------------------------------------
// zuma_lutram_bank
//
// Bank of CHANNELS independent K-input LUT truth tables held in LUTRAM. Each
// channel is read combinationally through its own read address. A handshaked
// loader writes all channels in parallel. Each accepted beat writes one
// truth-table entry, and the entry address increments automatically. This
// lets the configuration controller reprogram a whole mux column without
// generating addresses itself.
//
// Parameters
//   K          LUT input count; each channel holds 2**K entries.
//   CHANNELS   number of independent LUTs.
//   USED       0: bank unused. dpo is tied to 0 and loads are discarded, but
//              the loader still handshakes.
//   INIT_MASK  power-up contents. Channel c occupies [c*2**K +: 2**K].
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (loader only, not the tables)
//   cfg_start  starts a load; sampled only in IDLE
//   cfg_abort  terminates a load in progress; wins over a same-cycle beat
//   cfg_valid  beat valid
//   cfg_data   bit c is written to the current entry of channel c
//   cfg_ready  loader accepts a beat
//   cfg_busy   load in progress
//   cfg_done   one-cycle pulse after the final entry is written
//   dpra       read addresses; channel c uses [c*K +: K]
//   dpo        LUT outputs; forced to 0 while a load is in progress
//
// Build option
//   ZUMA_LUTRAM_OUTREG_EN  when defined, dpo is registered: read latency is
//                          1 cycle and the register resets to 0.
// ---------------------------------------------------------------------------
module zuma_lutram_bank #(
    parameter int                              K         = 6,
    parameter int                              CHANNELS  = 4,
    parameter int                              USED      = 1,
    parameter logic [CHANNELS*(2**K)-1:0]      INIT_MASK = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic                    cfg_valid,
    input  logic [CHANNELS-1:0]     cfg_data,
    output logic                    cfg_ready,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    input  logic [CHANNELS*K-1:0]   dpra,
    output logic [CHANNELS-1:0]     dpo
);

    localparam int DEPTH = 2**K;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                 state;
    logic [K-1:0]           addr;
    logic                   beat_accept;
    logic                   mem_we;
    logic [CHANNELS-1:0]    rd_bit;
    logic [CHANNELS-1:0]    dpo_comb;

    // Abort wins over a beat presented in the same cycle, so that beat is
    // never accepted or written.
    assign beat_accept = (state == S_LOAD) && cfg_valid && !cfg_abort;
    assign mem_we      = beat_accept && (USED != 0);

    // -----------------------------------------------------------------------
    // Loader FSM. cfg_ready, cfg_busy and cfg_done are registered alongside
    // the state so that they change only on clock edges.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop in
    // this block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        state     <= S_LOAD;
                        addr      <= '0;
                        cfg_ready <= 1'b1;
                        cfg_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cfg_abort) begin
                        state     <= S_IDLE;
                        cfg_ready <= 1'b0;
                        cfg_busy  <= 1'b0;
                    end else if (cfg_valid) begin
                        // The increment past the last entry wraps to 0, but
                        // the FSM leaves LOAD on that beat, so no second
                        // pass is ever written.
                        addr <= addr + 1'b1;
                        if (&addr) begin
                            state     <= S_IDLE;
                            cfg_ready <= 1'b0;
                            cfg_busy  <= 1'b0;
                            cfg_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b0;
                    cfg_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Truth tables: one DEPTH-bit LUTRAM per channel. All channels share the
    // loader address. Each channel has its own read port.
    // -----------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DEPTH-1:0] table_bits = INIT_MASK[c*DEPTH +: DEPTH];

        // NOTE: the table has no reset on purpose. LUTRAM cannot be cleared
        // in one cycle, so a reset mid-load keeps whatever was written.
        always_ff @(posedge clk) begin
            if (mem_we) begin
                table_bits[addr] <= cfg_data[c];
            end
        end

        assign rd_bit[c] = table_bits[dpra[c*K +: K]];
    end

    // Outputs are blanked during a load so the fabric never sees a
    // partially written table.
    always_comb begin
        dpo_comb = '0;
        if ((USED != 0) && !cfg_busy) begin
            dpo_comb = rd_bit;
        end
    end

`ifdef ZUMA_LUTRAM_OUTREG_EN
    // Gating sits before the register, so dpo stays 0 for one cycle after
    // cfg_busy falls.
    logic [CHANNELS-1:0] dpo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpo_q <= '0;
        end else begin
            dpo_q <= dpo_comb;
        end
    end

    assign dpo = dpo_q;
`else
    assign dpo = dpo_comb;
`endif

endmodule

// File: tb/tb_zuma_lutram_bank.sv
// ---------------------------------------------------------------------------
// tb_zuma_lutram_bank
//
// Self-checking bench for zuma_lutram_bank (K=6, CHANNELS=4).
// A behavioural model tracks the tables as plain 2-D bit arrays and tracks
// the loader as "loading / next entry". A compare process checks every
// output against that model on each falling edge. A second instance built
// with USED=0 shares the inputs and must keep dpo at 0. Fixed readbacks pin
// hand-computed table values.
// ---------------------------------------------------------------------------
module tb_zuma_lutram_bank;

    localparam int K      = 6;
    localparam int CH     = 4;
    localparam int DEPTH  = 2**K;
    localparam int BUDGET = 400;

    // ch3: odd entries 1; ch2: all 0; ch1: all 1; ch0: entries 0 and 63.
    localparam logic [CH*DEPTH-1:0] INIT_MASK = {
        64'hAAAA_AAAA_AAAA_AAAA,
        64'h0000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0001
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CH-1:0]     cfg_data = '0;
    logic [CH*K-1:0]   dpra = '0;
    logic              cfg_ready, cfg_busy, cfg_done;
    logic [CH-1:0]     dpo;
    logic              u_ready, u_busy, u_done;
    logic [CH-1:0]     u_dpo;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    zuma_lutram_bank #(.K(K), .CHANNELS(CH), .USED(1), .INIT_MASK(INIT_MASK)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .dpra(dpra), .dpo(dpo)
    );

    zuma_lutram_bank #(.K(K), .CHANNELS(CH), .USED(0), .INIT_MASK(INIT_MASK)) u_unused (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(u_ready),
        .cfg_busy(u_busy), .cfg_done(u_done), .dpra(dpra), .dpo(u_dpo)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            mdl_mem [CH][DEPTH];
    bit            mdl_loading;
    int            mdl_next;
    bit            mdl_done;
    logic [CH-1:0] mdl_dpo_q;

    initial begin
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < DEPTH; j++)
                mdl_mem[c][j] = INIT_MASK[c*DEPTH + j];
    end

    function automatic logic [CH-1:0] exp_comb();
        logic [CH-1:0] r;
        r = '0;
        if (!mdl_loading)
            for (int c = 0; c < CH; c++)
                r[c] = mdl_mem[c][int'(dpra[c*K +: K])];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_loading <= 1'b0;
            mdl_next    <= 0;
            mdl_done    <= 1'b0;
            mdl_dpo_q   <= '0;
        end else begin
            mdl_dpo_q <= exp_comb();
            mdl_done  <= 1'b0;
            if (!mdl_loading) begin
                if (cfg_start) begin
                    mdl_loading <= 1'b1;
                    mdl_next    <= 0;
                end
            end else if (cfg_abort) begin
                mdl_loading <= 1'b0;
            end else if (cfg_valid) begin
                for (int c = 0; c < CH; c++) mdl_mem[c][mdl_next] <= cfg_data[c];
                mdl_next <= mdl_next + 1;
                if (mdl_next == DEPTH - 1) begin
                    mdl_loading <= 1'b0;
                    mdl_done    <= 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [CH-1:0] exp_dpo;
`ifdef ZUMA_LUTRAM_OUTREG_EN
            exp_dpo = mdl_dpo_q;
`else
            exp_dpo = exp_comb();
`endif
            check("cmp_ready", 32'(cfg_ready), 32'(mdl_loading));
            check("cmp_busy",  32'(cfg_busy),  32'(mdl_loading));
            check("cmp_done",  32'(cfg_done),  32'(mdl_done));
            check("cmp_dpo",   32'(dpo),       32'(exp_dpo));
            check("cmp_unused_dpo",  32'(u_dpo),  32'd0);
            check("cmp_unused_done", 32'(u_done), 32'(mdl_done));
            check("cmp_unused_busy", 32'(u_busy), 32'(mdl_loading));
            if (cfg_done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [CH-1:0] pat_data(input int pat, input int beat);
        case (pat)
            0:       return beat[0] ? 4'b1010 : 4'b0101;
            1:       return 4'b0011;
            default: return 4'($urandom);
        endcase
    endfunction

    // vmode: 0 valid held, 1 valid toggling (starting low), 2 random valid.
    task automatic run_load(input int pat, input int vmode, input int abort_beat,
                            input int reset_beat, input int start_beat,
                            output int beats, output int cycles);
        logic v;
        beats  = 0;
        cycles = 0;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (beats < DEPTH && cycles < BUDGET) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = cycles[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            cfg_valid = v;
            cfg_data  = pat_data(pat, beats);
            dpra      = 24'($urandom);
            cfg_start = (beats == start_beat);
            cfg_abort = v && (beats == abort_beat);
            if (v && beats == reset_beat) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_ready", 32'(cfg_ready), 32'd0);
                check("rst_mid_busy",  32'(cfg_busy),  32'd0);
                check("rst_mid_done",  32'(cfg_done),  32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                cycles++;
                break;
            end
            @(posedge clk); #1;
            cycles++;
            if (cfg_abort) begin
                cfg_abort = 1'b0;
                break;
            end
            if (v) beats++;
        end
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_data  = '0;
    endtask

    task automatic readback(input string name, input int entry, input logic [CH-1:0] expected);
        dpra = {CH{6'(entry)}};
        @(posedge clk); #1;
        check(name, 32'(dpo), 32'(expected));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int beats, cycles, dc;

        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset_ready", 32'(cfg_ready), 32'd0);
        check("reset_busy",  32'(cfg_busy),  32'd0);
        check("reset_done",  32'(cfg_done),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Power-up contents.
        readback("init_e0",  0,  4'b0011);
        readback("init_e63", 63, 4'b1011);
        readback("init_e5",  5,  4'b1010);
        readback("init_e20", 20, 4'b0010);

        // Abort together with beat 20.
        dc = done_cnt;
        run_load(0, 0, 20, -1, -1, beats, cycles);
        check("abort_beats", 32'(beats), 32'd20);
        repeat (2) @(posedge clk); #1;
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        readback("abort_e19", 19, 4'b1010);
        readback("abort_e2",  2,  4'b0101);
        readback("abort_e20", 20, 4'b0010);
        readback("abort_e63", 63, 4'b1011);

        // Reset asserted while beat 20 is presented.
        dc = done_cnt;
        run_load(1, 0, -1, 20, -1, beats, cycles);
        repeat (2) @(posedge clk); #1;
        check("rst_no_done", 32'(done_cnt), 32'(dc));
        readback("rst_e19", 19, 4'b0011);
        readback("rst_e0",  0,  4'b0011);
        readback("rst_e20", 20, 4'b0010);

        // Full load, valid held high. It restarts at entry 0.
        dc = done_cnt;
        run_load(0, 0, -1, -1, -1, beats, cycles);
        check("full_beats",  32'(beats),  32'd64);
        check("full_cycles", 32'(cycles), 32'd64);
        check("full_done_now", 32'(cfg_done), 32'd1);
        @(posedge clk); #1;
        check("full_done_once", 32'(done_cnt), 32'(dc + 1));
        check("full_done_low", 32'(cfg_done), 32'd0);
        readback("full_e2",  2,  4'b0101);
        readback("full_e3",  3,  4'b1010);
        readback("full_e0",  0,  4'b0101);
        readback("full_e63", 63, 4'b1010);

        // Random data with random valid gaps; checked by the model.
        run_load(2, 2, -1, -1, -1, beats, cycles);
        check("rand_beats", 32'(beats), 32'd64);
        for (int i = 0; i < 100; i++) begin
            dpra = 24'($urandom);
            @(posedge clk); #1;
        end

        // Valid toggling every cycle.
        dc = done_cnt;
        run_load(0, 1, -1, -1, -1, beats, cycles);
        check("gap_beats",  32'(beats),  32'd64);
        check("gap_cycles", 32'(cycles), 32'd128);
        check("gap_done_now", 32'(cfg_done), 32'd1);
        @(posedge clk); #1;
        check("gap_done_once", 32'(done_cnt), 32'(dc + 1));
        readback("gap_e2",  2,  4'b0101);
        readback("gap_e3",  3,  4'b1010);
        readback("gap_e62", 62, 4'b0101);

        // cfg_start pulsed at beat 30 during a load is ignored.
        dc = done_cnt;
        run_load(1, 0, -1, -1, 30, beats, cycles);
        check("restart_beats",  32'(beats),  32'd64);
        check("restart_cycles", 32'(cycles), 32'd64);
        check("restart_done_now", 32'(cfg_done), 32'd1);
        @(posedge clk); #1;
        check("restart_done_once", 32'(done_cnt), 32'(dc + 1));
        readback("restart_e2",  2,  4'b0011);
        readback("restart_e63", 63, 4'b0011);

        // Random reads and a final random load with gaps.
        for (int i = 0; i < 100; i++) begin
            dpra = 24'($urandom);
            @(posedge clk); #1;
        end
        run_load(2, 2, -1, -1, -1, beats, cycles);
        for (int i = 0; i < 100; i++) begin
            dpra = 24'($urandom);
            @(posedge clk); #1;
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t limit 1000000", $time);
        $fatal(1, "watchdog");
    end

endmodule
